glb_sram_cfg_jtag_bridge: RTL and testbench

// - Upstream feeder of the tile SRAM-config chain. Turns single JTAG-side SRAM-config requests
//   (req/rsp handshake) into cfg_ifc transactions driven into tile 0's west port.
// - Waits for the read return that rides back along the chain, then reports data or a timeout.
// - Sits at GLB top, between the JTAG/axi-lite cfg decoder and tile 0; one transaction in flight.

---
 rtl/glb_sram_cfg_jtag_bridge_pkg.sv | 17 +
 rtl/cfg_ifc.sv | 30 +++
 rtl/glb_sram_cfg_jtag_bridge_rd_timer.sv | 34 +++
 rtl/glb_sram_cfg_jtag_bridge.sv | 172 +++++++++++++++++
 tb/tb_glb_sram_cfg_jtag_bridge.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/glb_sram_cfg_jtag_bridge_pkg.sv
// Shared types and width defaults for the JTAG-side SRAM-config bridge.
// Optional read timeout is enabled with GLB_SRAM_CFG_RD_TIMEOUT_EN.
package glb_sram_cfg_jtag_bridge_pkg;

    localparam int GLB_ADDR_WIDTH      = 22;
    localparam int CGRA_CFG_DATA_WIDTH = 32;
    localparam int GLB_RD_TIMEOUT      = 255;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_WAIT,
        RESP
    } sram_cfg_bridge_state_t;

endpackage

// File: rtl/cfg_ifc.sv
// SRAM-config chain port: write/read request pulses out, read return in.
// Used by the bridge as master into tile 0's west port.
interface cfg_ifc
    import glb_sram_cfg_jtag_bridge_pkg::*;
#(
    parameter int AW = GLB_ADDR_WIDTH,
    parameter int DW = CGRA_CFG_DATA_WIDTH
);
    logic          wr_en;
    logic          wr_clk_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          rd_clk_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;

    modport master (
        output wr_en, wr_clk_en, wr_addr, wr_data,
        output rd_en, rd_clk_en, rd_addr,
        input  rd_data, rd_data_valid
    );

    modport slave (
        input  wr_en, wr_clk_en, wr_addr, wr_data,
        input  rd_en, rd_clk_en, rd_addr,
        output rd_data, rd_data_valid
    );
endinterface

// File: rtl/glb_sram_cfg_jtag_bridge_rd_timer.sv
// Read-return watchdog counter; only built with GLB_SRAM_CFG_RD_TIMEOUT_EN.
// expired_o flags the cycle whose increment reaches RD_TIMEOUT.
module glb_cfg_rd_timer #(
    parameter int RD_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int TW = $clog2(RD_TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != TW'(RD_TIMEOUT))) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    assign expired_o = (cnt_q == TW'(RD_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/glb_sram_cfg_jtag_bridge.sv
// JTAG/axi-lite cfg request -> tile SRAM-config chain feeder, one txn in flight.
// Define GLB_SRAM_CFG_RD_TIMEOUT_EN to give up on reads after RD_TIMEOUT cycles.
module glb_sram_cfg_jtag_bridge
    import glb_sram_cfg_jtag_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = GLB_ADDR_WIDTH,
    parameter int DATA_WIDTH = CGRA_CFG_DATA_WIDTH,
    parameter int RD_TIMEOUT = GLB_RD_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    cfg_ifc.master                if_sram_cfg_m,
    output logic                  stale_rsp
);
    if ((RD_TIMEOUT < 1) || (RD_TIMEOUT > 65535)) begin : g_bad_timeout
        $error("RD_TIMEOUT must be in 1..65535");
    end

    sram_cfg_bridge_state_t state_q, state_d;

    logic                  req_ready_q;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  stale_q;

`ifdef GLB_SRAM_CFG_RD_TIMEOUT_EN
    logic tmr_clr, tmr_en, tmr_expired;

    glb_cfg_rd_timer #(
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_rd_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );
`else
    logic tmr_expired;
    assign tmr_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = '0;
        wr_data_d   = '0;
        rd_en_d     = 1'b0;
        rd_addr_d   = '0;
`ifdef GLB_SRAM_CFG_RD_TIMEOUT_EN
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (req_write) begin
                        state_d   = WR;
                        wr_en_d   = 1'b1;
                        wr_addr_d = req_addr;
                        wr_data_d = req_wdata;
                    end else begin
                        state_d   = RD;
                        rd_en_d   = 1'b1;
                        rd_addr_d = req_addr;
                    end
                end
            end
            WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            RD: begin
                state_d = RD_WAIT;
`ifdef GLB_SRAM_CFG_RD_TIMEOUT_EN
                tmr_clr = 1'b1;
`endif
            end
            RD_WAIT: begin
                // A return landing on the expiry cycle still counts as data.
                if (if_sram_cfg_m.rd_data_valid) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = if_sram_cfg_m.rd_data;
                end else begin
`ifdef GLB_SRAM_CFG_RD_TIMEOUT_EN
                    tmr_en = 1'b1;
`endif
                    if (tmr_expired) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            stale_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            stale_q     <= stale_q |
                           (if_sram_cfg_m.rd_data_valid && (state_q != RD_WAIT));
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign stale_rsp = stale_q;

    assign if_sram_cfg_m.wr_en     = wr_en_q;
    assign if_sram_cfg_m.wr_clk_en = 1'b1;
    assign if_sram_cfg_m.wr_addr   = wr_addr_q;
    assign if_sram_cfg_m.wr_data   = wr_data_q;
    assign if_sram_cfg_m.rd_en     = rd_en_q;
    assign if_sram_cfg_m.rd_clk_en = 1'b1;
    assign if_sram_cfg_m.rd_addr   = rd_addr_q;
endmodule

// File: tb/tb_glb_sram_cfg_jtag_bridge.sv
// Scoreboard bench for glb_sram_cfg_jtag_bridge with a delayed-return chain model.
// Timeout cases are built only when GLB_SRAM_CFG_RD_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_glb_sram_cfg_jtag_bridge;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          stale_rsp;

    cfg_ifc #(.AW(AW), .DW(DW)) cfg ();

    glb_sram_cfg_jtag_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .if_sram_cfg_m (cfg),
        .stale_rsp     (stale_rsp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    endfunction

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } rsp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } cfgx_t;

    rsp_t  rsp_q[$];
    cfgx_t cfg_q[$];
    int    rsp_rd = 0;
    int    cfg_rd = 0;

    // chain model: returns ret_data ret_delay cycles after rd_en (0 = never)
    int            ret_delay = 0;
    logic [DW-1:0] ret_data = '0;
    int            cd = 0;
    int            inj_req = 0;
    int            inj_ack = 0;

    always @(negedge clk) begin
        cfg.rd_data_valid = 1'b0;
        cfg.rd_data       = '0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                cfg.rd_data_valid = 1'b1;
                cfg.rd_data       = ret_data;
            end
        end
        if (cfg.rd_en && ret_delay > 0) cd = ret_delay;
        if (inj_req != inj_ack) begin
            inj_ack           = inj_req;
            cfg.rd_data_valid = 1'b1;
            cfg.rd_data       = 32'h5A5A_5A5A;
        end
    end

    // response monitor: compares every cycle rsp_valid is up, so a held
    // response must stay stable; pops on handshake
    bit   rsp_first = 1'b1;
    rsp_t re;
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            chk("rsp_expected", 64'(rsp_rd < rsp_q.size()), 1);
            if (rsp_rd < rsp_q.size()) begin
                re = rsp_q[rsp_rd];
                if (rsp_first) chk("rsp_cycle", 64'(cyc), 64'(re.cyc));
                chk("rsp_rdata", rsp_rdata, re.rdata);
                chk("rsp_err", rsp_err, re.err);
                rsp_first = 1'b0;
                if (rsp_ready) begin
                    rsp_rd++;
                    rsp_first = 1'b1;
                end
            end
        end
    end

    // cfg monitor: pulse contents, timing, width, and idle-zero outputs
    logic  prev_wr = 1'b0;
    logic  prev_rd = 1'b0;
    cfgx_t ce;
    always @(negedge clk) begin
        if (reset_n) begin
            if (cfg.wr_en || cfg.rd_en) begin
                chk("cfg_expected", 64'(cfg_rd < cfg_q.size()), 1);
                if (cfg.wr_en) chk("wr_en_width", prev_wr, 0);
                if (cfg.rd_en) chk("rd_en_width", prev_rd, 0);
                if (cfg_rd < cfg_q.size()) begin
                    ce = cfg_q[cfg_rd];
                    cfg_rd++;
                    chk("cfg_kind", cfg.wr_en, ce.wr);
                    chk("cfg_cycle", 64'(cyc), 64'(ce.cyc));
                    if (ce.wr) begin
                        chk("wr_addr", cfg.wr_addr, ce.addr);
                        chk("wr_data", cfg.wr_data, ce.data);
                    end else begin
                        chk("rd_addr", cfg.rd_addr, ce.addr);
                    end
                end
            end else begin
                chk("cfg_idle_zero",
                    64'(|{cfg.wr_addr, cfg.wr_data, cfg.rd_addr}), 0);
            end
            prev_wr = cfg.wr_en;
            prev_rd = cfg.rd_en;
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int acc);
        int n;
        n         = 0;
        acc       = -1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        while (acc < 0 && n < 200) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
            end
            n++;
        end
        req_valid = 1'b0;
        chk("accept_in_time", 64'(acc >= 0), 1);
        if (acc >= 0) begin
            cfg_q.push_back('{wr, a, wr ? d : '0, acc});
            if (wr) rsp_q.push_back('{'0, 1'b0, acc + 1});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(rsp_rd == rsp_q.size() && req_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 64'(n < 300), 1);
        @(posedge clk);
        #1;
    endtask

    int acc1, acc2;

    initial begin
        // reset state
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        chk("rst_cfg_en", {cfg.wr_en, cfg.rd_en}, 0);
        chk("rst_clk_en", {cfg.wr_clk_en, cfg.rd_clk_en}, 2'b11);
        chk("rst_stale", stale_rsp, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("req_ready_release", req_ready, 0);
        @(negedge clk);
        chk("req_ready_after", req_ready, 1);
        @(posedge clk);
        #1;

        // write
        issue(1'b1, 22'h01_2345, 32'hDEAD_BEEF, acc1);
        drain();

        // read, return 7 cycles after rd_en
        ret_delay = 7;
        ret_data  = 32'hCAFE_F00D;
        issue(1'b0, 22'h2A_5C3C, '0, acc1);
        rsp_q.push_back('{32'hCAFE_F00D, 1'b0, acc1 + 8});
        drain();

        // rsp_ready held low with a second request pending
        rsp_ready = 1'b0;
        issue(1'b1, 22'h3F_FFFF, 32'h1357_9BDF, acc1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 22'h00_0001;
        req_wdata = 32'h0F0F_0F0F;
        repeat (10) begin
            @(negedge clk);
            chk("held_req_ready", req_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        issue(1'b1, 22'h00_0001, 32'h0F0F_0F0F, acc2);
        drain();

        // back-to-back writes see one bubble
        issue(1'b1, 22'h10_0010, 32'hAAAA_5555, acc1);
        issue(1'b1, 22'h20_0020, 32'h5555_AAAA, acc2);
        chk("b2b_bubble", 64'(acc2 - acc1), 3);
        drain();
        chk("stale_clear", stale_rsp, 0);

`ifdef GLB_SRAM_CFG_RD_TIMEOUT_EN
        // no return -> timeout
        ret_delay = 0;
        issue(1'b0, 22'h05_0505, '0, acc1);
        rsp_q.push_back('{'0, 1'b1, acc1 + TO + 1});
        drain();
        chk("timeout_stale", stale_rsp, 0);

        // return on the expiry cycle -> data wins
        ret_delay = TO;
        ret_data  = 32'h1234_5678;
        issue(1'b0, 22'h06_0606, '0, acc1);
        rsp_q.push_back('{32'h1234_5678, 1'b0, acc1 + TO + 1});
        drain();

        // return one cycle too late -> timeout, then stale
        ret_delay = TO + 1;
        ret_data  = 32'h8765_4321;
        issue(1'b0, 22'h07_0707, '0, acc1);
        rsp_q.push_back('{'0, 1'b1, acc1 + TO + 1});
        drain();
        repeat (2) @(negedge clk);
        chk("late_stale", stale_rsp, 1);
`else
        // no timeout: a slow return still completes
        ret_delay = 40;
        ret_data  = 32'h0BAD_CAFE;
        issue(1'b0, 22'h05_0505, '0, acc1);
        rsp_q.push_back('{32'h0BAD_CAFE, 1'b0, acc1 + 41});
        drain();
        chk("slow_stale", stale_rsp, 0);
        inj_req++;
        repeat (3) @(negedge clk);
        chk("idle_stale", stale_rsp, 1);
        @(posedge clk);
        #1;
`endif

        // async reset in RD_WAIT aborts the read
        ret_delay = 0;
        issue(1'b0, 22'h11_1111, '0, acc1);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_req_ready", req_ready, 0);
        chk("arst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        chk("arst_cfg", {cfg.wr_en, cfg.rd_en, cfg.wr_addr, cfg.rd_addr}, 0);
        chk("arst_stale", stale_rsp, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        ret_delay = 7;
        ret_data  = 32'h600D_D00D;
        issue(1'b0, 22'h22_2222, '0, acc1);
        rsp_q.push_back('{32'h600D_D00D, 1'b0, acc1 + 8});
        drain();
        repeat (25) @(negedge clk);

        chk("all_rsp_seen", 64'(rsp_rd), 64'(rsp_q.size()));
        chk("all_cfg_seen", 64'(cfg_rd), 64'(cfg_q.size()));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end
endmodule
